ps2_scancode_rx: RTL and testbench

//   PS/2 keyboard receiver feeding the key decoder. Filters and synchronises kb_clk/data,

---
 rtl/ps2_scancode_rx.sv | 153 +++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronise/filter kb_clk, deserialise frames, fold F0/E0 prefixes.
// Optional parity rejection via `define PS2_PARITY_CHECK_EN (undefined: parity ignored).
`timescale 1ns/1ps
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kb_clk,
  input  logic       data,
  output logic [7:0] keycode,
  output logic       sign,
  output logic       valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  logic          kb_s1, kb_s2, d_s1, d_s2;
  logic          kb_filt, kb_filt_d;
  logic [FW-1:0] flt_cnt;
  logic          fall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kb_s1     <= 1'b1;
      kb_s2     <= 1'b1;
      d_s1      <= 1'b1;
      d_s2      <= 1'b1;
      kb_filt   <= 1'b1;
      kb_filt_d <= 1'b1;
      flt_cnt   <= '0;
    end else begin
      kb_s1     <= kb_clk;
      kb_s2     <= kb_s1;
      d_s1      <= data;
      d_s2      <= d_s1;
      kb_filt_d <= kb_filt;
      // Counts consecutive samples disagreeing with the filtered level
      if (kb_s2 == kb_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        kb_filt <= kb_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  assign fall = kb_filt_d & ~kb_filt;

  state_t        state, state_d;
  logic [3:0]    bit_cnt, bit_cnt_d;
  logic [8:0]    sh, sh_d;
  logic [TW-1:0] to_cnt, to_cnt_d;
  logic          brk, brk_d, ext, ext_d;
  logic [7:0]    keycode_d;
  logic          sign_d, valid_d, err_d;
  logic          good;

`ifdef PS2_PARITY_CHECK_EN
  assign good = d_s2 & (^sh);
`else
  assign good = d_s2;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      sh        <= '0;
      to_cnt    <= '0;
      brk       <= 1'b0;
      ext       <= 1'b0;
      keycode   <= 8'h00;
      sign      <= 1'b0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      sh        <= sh_d;
      to_cnt    <= to_cnt_d;
      brk       <= brk_d;
      ext       <= ext_d;
      keycode   <= keycode_d;
      sign      <= sign_d;
      valid     <= valid_d;
      frame_err <= err_d;
    end
  end

  // The frame verdict is taken on the stop-bit fall so the registered
  // valid/frame_err pulse lands in the single CHECK cycle.
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    sh_d      = sh;
    to_cnt_d  = to_cnt;
    brk_d     = brk;
    ext_d     = ext;
    keycode_d = keycode;
    sign_d    = sign;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    case (state)
      IDLE: begin
        if (fall && !d_s2) begin
          state_d   = RECV;
          bit_cnt_d = '0;
          to_cnt_d  = '0;
        end
      end
      RECV: begin
        if (fall) begin
          to_cnt_d = '0;
          if (bit_cnt == 4'd9) begin
            state_d = CHECK;
            if (!good) begin
              err_d = 1'b1;
            end else if (sh[7:0] == 8'hF0) begin
              brk_d = 1'b1;
            end else if (sh[7:0] == 8'hE0) begin
              ext_d = 1'b1;
            end else begin
              keycode_d = sh[7:0];
              sign_d    = ~brk;
              valid_d   = 1'b1;
              brk_d     = 1'b0;
              ext_d     = 1'b0;
            end
          end else begin
            sh_d      = {d_s2, sh[8:1]};
            bit_cnt_d = bit_cnt + 4'd1;
          end
        end else if (to_cnt == TW'(TIMEOUT_CYCLES)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt + TW'(1);
        end
      end
      CHECK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: directed PS/2 frames, expected pulses queued per frame.
`timescale 1ns/1ps
module tb_ps2_scancode_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 600;
  localparam int H          = 20;   // half bit period in clk cycles
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kb_clk = 1'b1;
  logic       data = 1'b1;
  logic [7:0] keycode;
  logic       sign, valid, frame_err;

  ps2_scancode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .kb_clk(kb_clk), .data(data),
    .keycode(keycode), .sign(sign), .valid(valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [7:0] kc;
    logic       sg;
  } exp_t;

  exp_t       q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] m_kc = 8'h00;
  logic       m_sg = 1'b0;
  logic       m_brk = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic badp);
    return {1'b1, (~^b) ^ badp, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      data = f[i];
      cycles(H);
      kb_clk = 1'b0;
      cycles(H);
      kb_clk = 1'b1;
    end
    @(posedge clk);
    data = 1'b1;
    cycles(4 * H);
  endtask

  task automatic send(input logic [7:0] b, input logic badp);
    if (PAR_EN && badp) begin
      q.push_back('{err: 1'b1, kc: m_kc, sg: m_sg});
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b != 8'hE0) begin
      m_kc  = b;
      m_sg  = ~m_brk;
      m_brk = 1'b0;
      q.push_back('{err: 1'b0, kc: m_kc, sg: m_sg});
    end
    send_bits(frame(b, badp), 11);
  endtask

  // Monitor: every output pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && (valid || frame_err)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {30'b0, valid, frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind", {30'b0, valid, frame_err}, e.err ? 32'd1 : 32'd2);
        chk("keycode", {24'b0, keycode}, {24'b0, e.kc});
        chk("sign", {31'b0, sign}, {31'b0, e.sg});
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_keycode"}, {24'b0, keycode}, 32'h00);
    chk({tag, "_sign"}, {31'b0, sign}, 32'd0);
    chk({tag, "_valid"}, {31'b0, valid}, 32'd0);
    chk({tag, "_frame_err"}, {31'b0, frame_err}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    cycles(5);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cycles(20);

    send(8'h29, 1'b0);                        // make 29
    send(8'hF0, 1'b0); send(8'h29, 1'b0);     // break 29
    send(8'hE0, 1'b0); send(8'h75, 1'b0);     // extended make 75
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
    send(8'h72, 1'b1);                        // flipped parity
    send(8'hF0, 1'b0); send(8'hF0, 1'b0); send(8'h1C, 1'b0);

    // Stalled partial frame must time out, then a clean frame follows
    send_bits(frame(8'h75, 1'b0), 5);
    q.push_back('{err: 1'b1, kc: m_kc, sg: m_sg});
    cycles(TIMEOUT + 100);
    send(8'h75, 1'b0);

    // Reset after a break prefix and in the middle of a frame
    send(8'hF0, 1'b0);
    send_bits(frame(8'h29, 1'b0), 5);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("midreset");
    m_kc  = 8'h00;
    m_sg  = 1'b0;
    m_brk = 1'b0;
    cycles(20);
    send(8'h29, 1'b0);

    cycles(50);
    chk("pending_expectations", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
